// File: rtl/counter_sw_ar_pkg.sv
// Shared types and sizing helpers for the push-button up/down counter.
//   rep_state_e : per-button press / auto-repeat state
//   max3        : largest of three cycle counts
//   cnt_width   : bits needed for a counter running 0 .. n-1 (at least 1)
package counter_sw_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DELAY,
      REPEAT_SLOW,
      REPEAT_FAST
   } rep_state_e;

   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/counter_sw_ar_if.sv
// Button/counter bundle between board-side logic and the counter.
//   switch_up_i / switch_down_i : raw active-low buttons (asynchronous)
//   mode_i                      : 0 saturate, 1 wrap
//   load_i / load_val_i         : single-cycle load strobe and value
//   counter_o, at_min_o, at_max_o, up_tick_o, down_tick_o : counter state
// slave is the counter side, master the side that drives the buttons.
interface counter_sw_ar_if #(
   parameter int unsigned WIDTH = 8
);
   logic             switch_up_i;
   logic             switch_down_i;
   logic             mode_i;
   logic             load_i;
   logic [WIDTH-1:0] load_val_i;
   logic [WIDTH-1:0] counter_o;
   logic             at_min_o;
   logic             at_max_o;
   logic             up_tick_o;
   logic             down_tick_o;

   modport master (
      output switch_up_i, switch_down_i, mode_i, load_i, load_val_i,
      input  counter_o, at_min_o, at_max_o, up_tick_o, down_tick_o
   );

   modport slave (
      input  switch_up_i, switch_down_i, mode_i, load_i, load_val_i,
      output counter_o, at_min_o, at_max_o, up_tick_o, down_tick_o
   );
endinterface

// File: rtl/counter_sw_ar_btn_repeat.sv
// One push button: 2-FF synchroniser, debounce, press / auto-repeat FSM.
//   clk_i     : clock
//   reset_i   : synchronous reset, active high
//   switch_ni : raw button, active low, asynchronous
//   tick_o    : registered 1-cycle pulse per press / repeat event
module btn_repeat
   import counter_sw_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES  = 500_000,
   parameter int unsigned REPEAT_DELAY     = 15_000_000,
   parameter int unsigned REPEAT_RATE      = 5_000_000,
   parameter int unsigned REPEAT_RATE_FAST = 1_000_000,
   parameter int unsigned FAST_AFTER       = 8
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic switch_ni,
   output logic tick_o
);

   localparam int unsigned DB_W  = cnt_width(DEBOUNCE_CYCLES);
   localparam int unsigned TMR_W = cnt_width(max3(REPEAT_DELAY, REPEAT_RATE, REPEAT_RATE_FAST));
   localparam int unsigned REP_W = cnt_width(FAST_AFTER);

   localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'(REPEAT_DELAY - 1);
   localparam logic [TMR_W-1:0] RATE_LAST  = TMR_W'(REPEAT_RATE - 1);
   localparam logic [TMR_W-1:0] FAST_LAST  = TMR_W'(REPEAT_RATE_FAST - 1);
   localparam logic [REP_W-1:0] REP_LAST   = REP_W'((FAST_AFTER > 0) ? FAST_AFTER - 1 : 0);

   logic [1:0]       sync_q;
   logic             db_q;
   logic [DB_W-1:0]  db_cnt_q;
   rep_state_e       state_q, state_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [REP_W-1:0] rep_q, rep_d;
   logic             tick_q, tick_d;

   // sync_q holds the inverted (active-high "pressed") level
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sync_q   <= '0;
         db_q     <= 1'b0;
         db_cnt_q <= '0;
      end else begin
         sync_q <= {sync_q[0], ~switch_ni};
         if (sync_q[1] == db_q) begin
            db_cnt_q <= '0;
         end else if (db_cnt_q == DB_LAST) begin
            db_q     <= sync_q[1];
            db_cnt_q <= '0;
         end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         timer_q <= '0;
         rep_q   <= '0;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         rep_q   <= rep_d;
         tick_q  <= tick_d;
      end
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      rep_d   = rep_q;
      tick_d  = 1'b0;
      if (!db_q) begin
         state_d = IDLE;
         timer_d = '0;
         rep_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               tick_d  = 1'b1;
               state_d = DELAY;
               timer_d = '0;
            end
            DELAY: begin
               if (timer_q == DELAY_LAST) begin
                  tick_d  = 1'b1;
                  timer_d = '0;
                  rep_d   = '0;
                  state_d = (FAST_AFTER == 0) ? REPEAT_FAST : REPEAT_SLOW;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
            REPEAT_SLOW: begin
               if (timer_q == RATE_LAST) begin
                  tick_d  = 1'b1;
                  timer_d = '0;
                  rep_d   = rep_q + 1'b1;
                  if (rep_q == REP_LAST) state_d = REPEAT_FAST;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
            REPEAT_FAST: begin
               if (timer_q == FAST_LAST) begin
                  tick_d  = 1'b1;
                  timer_d = '0;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign tick_o = tick_q;

endmodule

// File: rtl/counter_sw_ar.sv
// Up/down counter driven by two debounced, auto-repeating push buttons.
//   clk_i   : clock
//   reset_i : synchronous reset, active high
//   bus     : counter_sw_ar_if.slave -- buttons, mode, load in; value,
//             bound flags and applied-tick pulses out
module counter_sw_ar
   import counter_sw_pkg::*;
#(
   parameter int unsigned WIDTH            = 8,
   parameter int unsigned STEP             = 1,
   parameter int unsigned MIN_VAL          = 0,
   parameter int unsigned MAX_VAL          = 255,
   parameter int unsigned RESET_VAL        = 0,
   parameter int unsigned DEBOUNCE_CYCLES  = 500_000,
   parameter int unsigned REPEAT_DELAY     = 15_000_000,
   parameter int unsigned REPEAT_RATE      = 5_000_000,
   parameter int unsigned REPEAT_RATE_FAST = 1_000_000,
   parameter int unsigned FAST_AFTER       = 8
) (
   input  logic           clk_i,
   input  logic           reset_i,
   counter_sw_ar_if.slave bus
);

   localparam int unsigned AW = WIDTH + 2;
   typedef logic signed [AW-1:0] sval_t;

   localparam sval_t STEP_S = sval_t'(STEP);
   localparam sval_t MIN_S  = sval_t'(MIN_VAL);
   localparam sval_t MAX_S  = sval_t'(MAX_VAL);
   localparam sval_t ONE_S  = sval_t'(1);
   localparam logic [WIDTH-1:0] MIN_U = WIDTH'(MIN_VAL);
   localparam logic [WIDTH-1:0] MAX_U = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] RST_U = WIDTH'(RESET_VAL);

   logic             up_raw, dn_raw;
   logic             up_tick_q, dn_tick_q;
   logic [WIDTH-1:0] count_q;
   sval_t            cur_s, load_s, up_v, dn_v, up_w, dn_w, load_w;
   logic [WIDTH-1:0] up_next, dn_next, load_next;

   btn_repeat #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE),
      .REPEAT_RATE_FAST(REPEAT_RATE_FAST),
      .FAST_AFTER      (FAST_AFTER)
   ) u_btn_up (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .switch_ni(bus.switch_up_i),
      .tick_o   (up_raw)
   );

   btn_repeat #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE),
      .REPEAT_RATE_FAST(REPEAT_RATE_FAST),
      .FAST_AFTER      (FAST_AFTER)
   ) u_btn_dn (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .switch_ni(bus.switch_down_i),
      .tick_o   (dn_raw)
   );

   // Signed arithmetic two bits wider than the counter so neither c+STEP
   // nor c-STEP can overflow before the bound checks.
   always_comb begin
      cur_s  = sval_t'({2'b00, count_q});
      load_s = sval_t'({2'b00, bus.load_val_i});
      up_v   = cur_s + STEP_S;
      dn_v   = cur_s - STEP_S;

      up_w = up_v;
      if (up_v > MAX_S) up_w = bus.mode_i ? (MIN_S + (up_v - MAX_S - ONE_S)) : MAX_S;
      dn_w = dn_v;
      if (dn_v < MIN_S) dn_w = bus.mode_i ? (MAX_S - (MIN_S - dn_v - ONE_S)) : MIN_S;

      load_w = load_s;
      if (load_s < MIN_S)      load_w = MIN_S;
      else if (load_s > MAX_S) load_w = MAX_S;

      up_next   = WIDTH'(up_w);
      dn_next   = WIDTH'(dn_w);
      load_next = WIDTH'(load_w);
   end

   // The applied-tick register sits between the button FSMs and the counter:
   // simultaneous up/down or a concurrent load cancels the tick here, and the
   // counter takes the surviving tick one cycle later (a load then still wins).
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count_q   <= RST_U;
         up_tick_q <= 1'b0;
         dn_tick_q <= 1'b0;
      end else begin
         up_tick_q <= up_raw & ~dn_raw & ~bus.load_i;
         dn_tick_q <= dn_raw & ~up_raw & ~bus.load_i;
         if (bus.load_i)     count_q <= load_next;
         else if (up_tick_q) count_q <= up_next;
         else if (dn_tick_q) count_q <= dn_next;
      end
   end

   assign bus.counter_o   = count_q;
   assign bus.at_min_o    = (count_q == MIN_U);
   assign bus.at_max_o    = (count_q == MAX_U);
   assign bus.up_tick_o   = up_tick_q;
   assign bus.down_tick_o = dn_tick_q;

endmodule

// File: tb/tb_counter_sw_ar.sv
module tb_counter_sw_ar;

   typedef struct {
      logic        rst;
      logic        up_n;
      logic        dn_n;
      logic        mode;
      logic        load;
      logic [3:0]  val;
      int unsigned edges;
      int unsigned cnt;
      int unsigned nup;
      int unsigned ndn;
      logic        amin;
      logic        amax;
   } vec_t;

   vec_t vecs[$];

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int unsigned total = 0;
   int unsigned bad   = 0;
   int unsigned nup   = 0;
   int unsigned ndn   = 0;

   counter_sw_ar_if #(.WIDTH(4)) bus ();

   counter_sw_ar #(
      .WIDTH           (4),
      .STEP            (3),
      .MIN_VAL         (2),
      .MAX_VAL         (12),
      .RESET_VAL       (2),
      .DEBOUNCE_CYCLES (4),
      .REPEAT_DELAY    (20),
      .REPEAT_RATE     (5),
      .REPEAT_RATE_FAST(2),
      .FAST_AFTER      (3)
   ) dut (
      .clk_i  (clk),
      .reset_i(rst),
      .bus    (bus)
   );

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input int unsigned n);
      repeat (n) begin
         @(posedge clk);
         #1;
         if (bus.up_tick_o)   nup++;
         if (bus.down_tick_o) ndn++;
      end
   endtask

   task automatic add(input logic r, input logic u, input logic d, input logic m,
                      input logic l, input logic [3:0] v, input int unsigned e,
                      input int unsigned c, input int unsigned nu, input int unsigned nd,
                      input logic mn, input logic mx);
      vec_t t;
      t = '{r, u, d, m, l, v, e, c, nu, nd, mn, mx};
      vecs.push_back(t);
   endtask

   task automatic do_load(input logic [3:0] v);
      bus.load_i     = 1'b1;
      bus.load_val_i = v;
      step(1);
      bus.load_i     = 1'b0;
   endtask

   initial begin
      int unsigned exp_t[8] = '{7, 27, 32, 37, 42, 44, 46, 48};
      int unsigned got[$];

      bus.switch_up_i   = 1'b1;
      bus.switch_down_i = 1'b1;
      bus.mode_i        = 1'b0;
      bus.load_i        = 1'b0;
      bus.load_val_i    = '0;

      //   rst up dn md ld val edges | cnt nup ndn min max
      add(1, 1, 1, 0, 0,  0,  2,  2, 0, 0, 1, 0);   // reset state
      add(0, 0, 1, 0, 0,  0,  3,  2, 0, 0, 1, 0);   // 3-cycle glitch
      add(0, 1, 1, 0, 0,  0, 12,  2, 0, 0, 1, 0);
      add(0, 0, 1, 0, 0,  0,  7,  2, 0, 0, 1, 0);   // press, edges 0..6
      add(0, 0, 1, 0, 0,  0,  1,  2, 1, 0, 1, 0);   // tick at edge 7
      add(0, 0, 1, 0, 0,  0,  1,  5, 0, 0, 0, 0);   // update at edge 8
      add(0, 0, 1, 0, 0,  0,  1,  5, 0, 0, 0, 0);
      add(0, 1, 1, 0, 0,  0, 20,  5, 0, 0, 0, 0);   // release
      add(0, 1, 1, 1, 1, 11,  1, 11, 0, 0, 0, 0);   // wrap up 11 -> 3
      add(0, 0, 1, 1, 0,  0,  7, 11, 0, 0, 0, 0);
      add(0, 0, 1, 1, 0,  0,  1, 11, 1, 0, 0, 0);
      add(0, 0, 1, 1, 0,  0,  1,  3, 0, 0, 0, 0);
      add(0, 1, 1, 1, 0,  0, 20,  3, 0, 0, 0, 0);
      add(0, 1, 1, 1, 1,  3,  1,  3, 0, 0, 0, 0);   // wrap down 3 -> 11
      add(0, 1, 0, 1, 0,  0,  8,  3, 0, 1, 0, 0);
      add(0, 1, 0, 1, 0,  0,  1, 11, 0, 0, 0, 0);
      add(0, 1, 1, 1, 0,  0, 20, 11, 0, 0, 0, 0);
      add(0, 1, 1, 1, 1, 12,  1, 12, 0, 0, 0, 1);   // wrap up 12 -> 4
      add(0, 0, 1, 1, 0,  0,  8, 12, 1, 0, 0, 1);
      add(0, 0, 1, 1, 0,  0,  1,  4, 0, 0, 0, 0);
      add(0, 1, 1, 1, 0,  0, 20,  4, 0, 0, 0, 0);
      add(0, 1, 1, 1, 1, 15,  1, 12, 0, 0, 0, 1);   // load clamps
      add(0, 1, 1, 1, 1,  0,  1,  2, 0, 0, 1, 0);
      add(0, 1, 1, 1, 1,  7,  1,  7, 0, 0, 0, 0);
      add(0, 1, 1, 0, 0,  0,  3,  7, 0, 0, 0, 0);   // mode change alone
      add(0, 1, 1, 1, 0,  0,  3,  7, 0, 0, 0, 0);
      add(0, 1, 1, 0, 1,  3,  1,  3, 0, 0, 0, 0);   // saturate down 3 -> 2
      add(0, 1, 0, 0, 0,  0,  8,  3, 0, 1, 0, 0);
      add(0, 1, 0, 0, 0,  0,  1,  2, 0, 0, 1, 0);
      add(0, 1, 1, 0, 0,  0, 20,  2, 0, 0, 1, 0);
      add(0, 1, 1, 0, 1, 11,  1, 11, 0, 0, 0, 0);   // saturate up 11 -> 12
      add(0, 0, 1, 0, 0,  0,  8, 11, 1, 0, 0, 0);
      add(0, 0, 1, 0, 0,  0,  1, 12, 0, 0, 0, 1);
      add(0, 1, 1, 0, 0,  0, 20, 12, 0, 0, 0, 1);

      foreach (vecs[i]) begin
         rst               = vecs[i].rst;
         bus.switch_up_i   = vecs[i].up_n;
         bus.switch_down_i = vecs[i].dn_n;
         bus.mode_i        = vecs[i].mode;
         bus.load_i        = vecs[i].load;
         bus.load_val_i    = vecs[i].val;
         nup = 0;
         ndn = 0;
         step(vecs[i].edges);
         check($sformatf("row%0d counter", i), bus.counter_o, vecs[i].cnt);
         check($sformatf("row%0d up_ticks", i), nup, vecs[i].nup);
         check($sformatf("row%0d down_ticks", i), ndn, vecs[i].ndn);
         check($sformatf("row%0d at_min", i), bus.at_min_o, vecs[i].amin);
         check($sformatf("row%0d at_max", i), bus.at_max_o, vecs[i].amax);
      end
      bus.load_i = 1'b0;

      // Repeat timing while saturated at the top
      bus.mode_i = 1'b0;
      do_load(4'd11);
      bus.switch_up_i = 1'b0;
      for (int unsigned e = 0; e < 50; e++) begin
         step(1);
         if (bus.up_tick_o) got.push_back(e);
      end
      check("repeat_count", got.size(), 8);
      for (int unsigned i = 0; i < 8; i++)
         check($sformatf("repeat_edge%0d", i), (i < got.size()) ? got[i] : 32'hFFFF, exp_t[i]);
      check("sat_hold counter", bus.counter_o, 12);
      check("sat_hold at_max", bus.at_max_o, 1);
      bus.switch_up_i = 1'b1;
      step(20);
      check("sat_release counter", bus.counter_o, 12);

      // Both buttons held together
      do_load(4'd7);
      nup = 0;
      ndn = 0;
      bus.switch_up_i   = 1'b0;
      bus.switch_down_i = 1'b0;
      step(30);
      check("both up_ticks", nup, 0);
      check("both down_ticks", ndn, 0);
      check("both counter", bus.counter_o, 7);
      bus.switch_up_i   = 1'b1;
      bus.switch_down_i = 1'b1;
      step(20);

      // Load while an up tick is pending
      do_load(4'd5);
      bus.switch_up_i = 1'b0;
      step(7);
      step(1);
      check("loadwin tick", bus.up_tick_o, 1);
      bus.load_i     = 1'b1;
      bus.load_val_i = 4'd9;
      step(1);
      bus.load_i = 1'b0;
      check("loadwin counter", bus.counter_o, 9);
      step(1);
      check("loadwin after", bus.counter_o, 9);
      bus.switch_up_i = 1'b1;
      step(20);
      check("loadwin release", bus.counter_o, 9);

      // Reset while the button is still held
      bus.switch_up_i = 1'b0;
      step(20);
      rst = 1'b1;
      step(2);
      check("rst_hold counter", bus.counter_o, 2);
      check("rst_hold tick", bus.up_tick_o, 0);
      rst = 1'b0;
      nup = 0;
      step(7);
      check("refire early_ticks", nup, 0);
      check("refire early_counter", bus.counter_o, 2);
      step(1);
      check("refire tick", bus.up_tick_o, 1);
      step(1);
      check("refire counter", bus.counter_o, 5);
      bus.switch_up_i = 1'b1;
      step(20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
